// File: rtl/sched_pkg.sv
// Shared definitions for the axon scheduler: error codes, FSM states,
// packet field offsets and a saturating counter helper.
package sched_pkg;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_CUR_TICK   = 2'b01;
  localparam logic [1:0] ERR_ZERO_DELAY = 2'b10;
  localparam logic [1:0] ERR_WHILE_ERR  = 2'b11;

  localparam int PKT_DBG_W = 2;

  typedef enum logic {
    S_RUN = 1'b0,
    S_ERR = 1'b1
  } sched_state_e;

  // Packet layout, MSB first: {tick_field, axon_id, debug[1:0]}
  function automatic int pkt_axon_msb(input int axon_w);
    return axon_w + PKT_DBG_W - 1;
  endfunction

  function automatic int pkt_tick_lsb(input int axon_w);
    return axon_w + PKT_DBG_W;
  endfunction

  function automatic int pkt_tick_msb(input int axon_w, input int tick_w);
    return axon_w + tick_w + PKT_DBG_W - 1;
  endfunction

  function automatic int pkt_width(input int axon_w, input int tick_w);
    return axon_w + tick_w + PKT_DBG_W;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    logic [15:0] r;
    if (en && (v != 16'hFFFF)) begin
      r = v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sched_row_mem.sv
// Circular spike buffer: NUM_TICKS rows of NUM_AXONS bits with set-bit,
// clear-row and row-read ports. SCHED_STATS_EN adds a "bit already set" probe.
module sched_row_mem
  import sched_pkg::*;
#(
  parameter int NUM_AXONS = 256,
  parameter int NUM_TICKS = 16,
  parameter int AXON_W    = $clog2(NUM_AXONS),
  parameter int TICK_W    = $clog2(NUM_TICKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [TICK_W-1:0]    set_row,
  input  logic [AXON_W-1:0]    set_axon,
  input  logic                 clr_en,
  input  logic [TICK_W-1:0]    clr_row,
  input  logic [TICK_W-1:0]    rd_row,
  output logic [NUM_AXONS-1:0] rd_data
`ifdef SCHED_STATS_EN
  ,
  output logic                 set_hit
`endif
);

  logic [NUM_AXONS-1:0] rows_q [NUM_TICKS];
  logic [NUM_AXONS-1:0] rows_d [NUM_TICKS];

  assign rd_data = rows_q[rd_row];

`ifdef SCHED_STATS_EN
  assign set_hit = rows_q[set_row][set_axon];
`endif

  // Next row contents: set one bit in the target row, zero the cleared row
  always_comb begin
    rows_d = rows_q;
    if (set_en) begin
      rows_d[set_row][set_axon] = 1'b1;
    end else begin
      rows_d[set_row] = rows_q[set_row];
    end
    if (clr_en) begin
      rows_d[clr_row] = '0;
    end else begin
      rows_d[clr_row] = rows_d[clr_row];
    end
  end

  // Row storage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TICKS; i++) begin
        rows_q[i] <= '0;
      end
    end else begin
      rows_q <= rows_d;
    end
  end

endmodule

// File: rtl/axon_scheduler.sv
// Spike scheduler: buffers router spikes per delivery tick and hands the current
// row to the token controller. Define SCHED_STATS_EN for saturating statistics.
module axon_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_AXONS  = 256,
  parameter int NUM_TICKS  = 16,
  parameter int AXON_W     = $clog2(NUM_AXONS),
  parameter int TICK_W     = $clog2(NUM_TICKS),
  parameter int DELAY_MODE = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [pkt_width(AXON_W, TICK_W)-1:0]   spike_packet,
  input  logic                                   spike_packet_valid,
  output logic                                   spike_packet_ready,
  input  logic                                   read_request,
  output logic [NUM_AXONS-1:0]                   current_tick_spikes,
  output logic                                   spikes_valid,
  input  logic                                   clear_request,
  output logic                                   error,
  output logic [1:0]                             error_code,
  input  logic                                   error_ack,
  output logic [TICK_W-1:0]                      current_tick
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]                            stat_accepted,
  output logic [15:0]                            stat_dropped,
  output logic [15:0]                            stat_dup
`endif
);

  sched_state_e         state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 error_q, error_d;
  logic [1:0]           code_q, code_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [NUM_AXONS-1:0] spikes_q, spikes_d;
  logic                 spikes_valid_q, spikes_valid_d;

  logic [TICK_W-1:0]    tick_field_s;
  logic [AXON_W-1:0]    axon_id_s;
  logic [TICK_W-1:0]    target_s;
  logic                 bad_s;
  logic [1:0]           bad_code_s;
  logic                 set_en_s;
  logic                 clr_en_s;
  logic [NUM_AXONS-1:0] rd_row_s;
  logic                 pkt_debug_unused_s;

  assign tick_field_s       = spike_packet[pkt_tick_msb(AXON_W, TICK_W):pkt_tick_lsb(AXON_W)];
  assign axon_id_s          = spike_packet[pkt_axon_msb(AXON_W):PKT_DBG_W];
  assign pkt_debug_unused_s = ^spike_packet[PKT_DBG_W-1:0];

  // Delivery row and illegal-write detection, both against the pre-advance tick
  always_comb begin
    if (DELAY_MODE == 32'sd1) begin
      target_s   = tick_q + tick_field_s;
      bad_s      = (tick_field_s == '0);
      bad_code_s = ERR_ZERO_DELAY;
    end else begin
      target_s   = tick_field_s;
      bad_s      = (tick_field_s == tick_q);
      bad_code_s = ERR_CUR_TICK;
    end
  end

  // FSM next state, error reporting, read capture and tick advance
  always_comb begin
    state_d        = state_q;
    error_d        = error_q;
    code_d         = code_q;
    tick_d         = tick_q;
    spikes_d       = spikes_q;
    spikes_valid_d = 1'b0;
    set_en_s       = 1'b0;
    clr_en_s       = 1'b0;

    case (state_q)
      S_RUN: begin
        if (spike_packet_valid) begin
          if (bad_s) begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = bad_code_s;
          end else begin
            set_en_s = 1'b1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_ERR: begin
        if (error_ack) begin
          state_d = S_RUN;
          error_d = 1'b0;
          // A packet still being offered during the ack is reported, not taken
          if (spike_packet_valid) begin
            code_d = ERR_WHILE_ERR;
          end else begin
            code_d = code_q;
          end
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_RUN;
        error_d = 1'b0;
        code_d  = ERR_NONE;
      end
    endcase

    if (read_request) begin
      spikes_d       = rd_row_s;
      spikes_valid_d = 1'b1;
    end else begin
      spikes_d       = spikes_q;
    end

    if (clear_request) begin
      clr_en_s = 1'b1;
      tick_d   = tick_q + TICK_W'(1'b1);
    end else begin
      tick_d   = tick_q;
    end

    ready_d = (state_d == S_RUN);
  end

  // Control and read-out registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      ready_q        <= 1'b1;
      error_q        <= 1'b0;
      code_q         <= ERR_NONE;
      tick_q         <= '0;
      spikes_q       <= '0;
      spikes_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      error_q        <= error_d;
      code_q         <= code_d;
      tick_q         <= tick_d;
      spikes_q       <= spikes_d;
      spikes_valid_q <= spikes_valid_d;
    end
  end

  assign spike_packet_ready  = ready_q;
  assign error               = error_q;
  assign error_code          = code_q;
  assign current_tick        = tick_q;
  assign current_tick_spikes = spikes_q;
  assign spikes_valid        = spikes_valid_q;

`ifdef SCHED_STATS_EN
  logic        set_hit_s;
  logic        drop_s;
  logic [15:0] acc_q, acc_d;
  logic [15:0] drop_q, drop_d;
  logic [15:0] dup_q, dup_d;

  assign drop_s = spike_packet_valid && (state_q == S_RUN) && bad_s;

  // Saturating statistics; a duplicate is still an accepted write
  always_comb begin
    acc_d  = sat_inc16(acc_q, set_en_s);
    dup_d  = sat_inc16(dup_q, set_en_s & set_hit_s);
    drop_d = sat_inc16(drop_q, drop_s);
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 16'd0;
      drop_q <= 16'd0;
      dup_q  <= 16'd0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
      dup_q  <= dup_d;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_dropped  = drop_q;
  assign stat_dup      = dup_q;
`endif

  sched_row_mem #(
    .NUM_AXONS (NUM_AXONS),
    .NUM_TICKS (NUM_TICKS),
    .AXON_W    (AXON_W),
    .TICK_W    (TICK_W)
  ) u_row_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en_s),
    .set_row  (target_s),
    .set_axon (axon_id_s),
    .clr_en   (clr_en_s),
    .clr_row  (tick_q),
    .rd_row   (tick_q),
    .rd_data  (rd_row_s)
`ifdef SCHED_STATS_EN
    ,
    .set_hit  (set_hit_s)
`endif
  );

endmodule

// File: tb/tb_axon_scheduler.sv
// Bench for axon_scheduler: two instances (absolute and relative delay modes)
// checked every cycle against a row/tick model, plus directed literal checks.
module tb_axon_scheduler;

  localparam int NA = 256;
  localparam int NT = 16;
  localparam int AW = 8;
  localparam int TW = 4;
  localparam int PW = TW + AW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [PW-1:0] pkt   [2];
  logic          valid [2];
  logic          rd    [2];
  logic          clr   [2];
  logic          ack   [2];
  logic          ready [2];
  logic          sv    [2];
  logic          err   [2];
  logic [1:0]    code  [2];
  logic [TW-1:0] tick  [2];
  logic [NA-1:0] spk   [2];
`ifdef SCHED_STATS_EN
  logic [15:0]   s_acc [2];
  logic [15:0]   s_drop[2];
  logic [15:0]   s_dup [2];
`endif

  axon_scheduler #(.NUM_AXONS(NA), .NUM_TICKS(NT), .DELAY_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .spike_packet(pkt[0]), .spike_packet_valid(valid[0]),
    .spike_packet_ready(ready[0]), .read_request(rd[0]), .current_tick_spikes(spk[0]),
    .spikes_valid(sv[0]), .clear_request(clr[0]), .error(err[0]), .error_code(code[0]),
    .error_ack(ack[0]), .current_tick(tick[0])
`ifdef SCHED_STATS_EN
    , .stat_accepted(s_acc[0]), .stat_dropped(s_drop[0]), .stat_dup(s_dup[0])
`endif
  );

  axon_scheduler #(.NUM_AXONS(NA), .NUM_TICKS(NT), .DELAY_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .spike_packet(pkt[1]), .spike_packet_valid(valid[1]),
    .spike_packet_ready(ready[1]), .read_request(rd[1]), .current_tick_spikes(spk[1]),
    .spikes_valid(sv[1]), .clear_request(clr[1]), .error(err[1]), .error_code(code[1]),
    .error_ack(ack[1]), .current_tick(tick[1])
`ifdef SCHED_STATS_EN
    , .stat_accepted(s_acc[1]), .stat_dropped(s_drop[1]), .stat_dup(s_dup[1])
`endif
  );

  // Reference model: index 0 is absolute mode, index 1 relative mode
  logic [NA-1:0] m_rows [2][NT];
  int            m_tick [2];
  bit            m_err  [2];
  logic [1:0]    m_code [2];
  logic [NA-1:0] m_spk  [2];
  bit            m_sv   [2];
  int            m_acc  [2];
  int            m_drop [2];
  int            m_dup  [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [NA-1:0] act, input logic [NA-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NT; r++) m_rows[d][r] = '0;
      m_tick[d] = 0; m_err[d] = 0; m_code[d] = 2'b00;
      m_spk[d] = '0; m_sv[d] = 0;
      m_acc[d] = 0; m_drop[d] = 0; m_dup[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int tf, ax, tgt;
    bit illegal;
    logic [NA-1:0] cur_row;
    cur_row = m_rows[d][m_tick[d]];
    tf = int'(pkt[d][PW-1:AW+2]);
    ax = int'(pkt[d][AW+1:2]);
    if (!m_err[d] && valid[d]) begin
      if (d == 1) begin
        tgt = (m_tick[d] + tf) % NT;
        illegal = (tf == 0);
      end else begin
        tgt = tf;
        illegal = (tgt == m_tick[d]);
      end
      if (illegal) begin
        m_err[d]  = 1;
        m_code[d] = (d == 1) ? 2'b10 : 2'b01;
        m_drop[d]++;
      end else begin
        if (m_rows[d][tgt][ax]) m_dup[d]++;
        m_rows[d][tgt][ax] = 1'b1;
        m_acc[d]++;
      end
    end else if (m_err[d] && ack[d]) begin
      m_err[d] = 0;
      if (valid[d]) m_code[d] = 2'b11;
    end
    m_sv[d] = rd[d];
    if (rd[d]) m_spk[d] = cur_row;
    if (clr[d]) begin
      m_rows[d][m_tick[d]] = '0;
      m_tick[d] = (m_tick[d] + 1) % NT;
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_ready", d), NA'(ready[d]), NA'(!m_err[d]));
      chk($sformatf("d%0d_error", d), NA'(err[d]),   NA'(m_err[d]));
      chk($sformatf("d%0d_code", d),  NA'(code[d]),  NA'(m_code[d]));
      chk($sformatf("d%0d_tick", d),  NA'(tick[d]),  NA'(m_tick[d]));
      chk($sformatf("d%0d_sv", d),    NA'(sv[d]),    NA'(m_sv[d]));
      chk($sformatf("d%0d_spikes", d), spk[d],       m_spk[d]);
`ifdef SCHED_STATS_EN
      chk($sformatf("d%0d_acc", d),  NA'(s_acc[d]),  NA'(m_acc[d]));
      chk($sformatf("d%0d_drop", d), NA'(s_drop[d]), NA'(m_drop[d]));
      chk($sformatf("d%0d_dup", d),  NA'(s_dup[d]),  NA'(m_dup[d]));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; rd[d] = 1'b0; clr[d] = 1'b0; ack[d] = 1'b0;
    end
  endtask

  task automatic set_pkt(input int d, input int tf, input int ax);
    pkt[d] = {TW'(tf), AW'(ax), 2'($urandom_range(0, 3))};
  endtask

  task automatic write1(input int d, input int tf, input int ax);
    set_pkt(d, tf, ax);
    valid[d] = 1'b1;
    cyc();
    idle();
  endtask

  task automatic read1(input int d);
    rd[d] = 1'b1;
    cyc();
    idle();
  endtask

  task automatic clear1(input int d);
    clr[d] = 1'b1;
    cyc();
    idle();
  endtask

  task automatic ack1(input int d, input bit with_valid);
    ack[d] = 1'b1;
    valid[d] = with_valid;
    cyc();
    idle();
  endtask

  logic [NA-1:0] e;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) pkt[d] = '0;
    idle();
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;

    // Reset values
    chk("lit_rst_tick", NA'(tick[0]), NA'(4'd0));
    chk("lit_rst_ready", NA'(ready[0]), NA'(1'b1));
    chk("lit_rst_err", NA'(err[0]), NA'(1'b0));
    chk("lit_rst_code", NA'(code[0]), NA'(2'b00));
    chk("lit_rst_spk", spk[0], '0);

    // Absolute mode directed sequence
    write1(0, 1, 5); write1(0, 1, 10); write1(0, 1, 20); write1(0, 2, 50); write1(0, 5, 200);
    read1(0);
    chk("lit_read0_spk", spk[0], '0);
    chk("lit_read0_sv", NA'(sv[0]), NA'(1'b1));
    cyc();
    chk("lit_sv_drop", NA'(sv[0]), NA'(1'b0));
    clear1(0);
    chk("lit_tick1", NA'(tick[0]), NA'(4'd1));
    read1(0);
    e = '0; e[5] = 1'b1; e[10] = 1'b1; e[20] = 1'b1;
    chk("lit_row1", spk[0], e);
    cyc();
    chk("lit_row1_sv_drop", NA'(sv[0]), NA'(1'b0));

    write1(0, 2, 100);
    clear1(0);
    rd[0] = 1'b1; clr[0] = 1'b1; cyc(); idle();
    e = '0; e[50] = 1'b1; e[100] = 1'b1;
    chk("lit_rdclr_spk", spk[0], e);
    chk("lit_rdclr_tick", NA'(tick[0]), NA'(4'd3));

    repeat (3) clear1(0);
    write1(0, 6, 80);
    chk("lit_cur_err", NA'(err[0]), NA'(1'b1));
    chk("lit_cur_code", NA'(code[0]), NA'(2'b01));
    chk("lit_cur_ready", NA'(ready[0]), NA'(1'b0));
    set_pkt(0, 6, 80);
    ack1(0, 1'b1);
    chk("lit_ack_err", NA'(err[0]), NA'(1'b0));
    chk("lit_ack_code", NA'(code[0]), NA'(2'b11));
    chk("lit_ack_ready", NA'(ready[0]), NA'(1'b1));
    read1(0);
    chk("lit_no_bit80", spk[0], '0);

    repeat (9) clear1(0);
    chk("lit_tick15", NA'(tick[0]), NA'(4'd15));
    set_pkt(0, 0, 1); valid[0] = 1'b1; clr[0] = 1'b1; cyc(); idle();
    chk("lit_wrap_tick", NA'(tick[0]), NA'(4'd0));
    read1(0);
    chk("lit_wrap_row0", spk[0], NA'(2'b10));
    repeat (2) clear1(0);
    read1(0);
    chk("lit_row2_zeroed", spk[0], '0);

    write1(0, 3, 9); write1(0, 3, 9); write1(0, 2, 7);
    chk("lit_stat_err_code", NA'(code[0]), NA'(2'b01));
    ack1(0, 1'b0);
    chk("lit_plain_ack_code", NA'(code[0]), NA'(2'b01));
`ifdef SCHED_STATS_EN
    chk("lit_stat_acc", NA'(s_acc[0]), NA'(16'd9));
    chk("lit_stat_dup", NA'(s_dup[0]), NA'(16'd1));
    chk("lit_stat_drop", NA'(s_drop[0]), NA'(16'd2));
`endif

    // Relative mode directed sequence
    for (int i = 0; i < 14; i++) clear1(1);
    chk("lit_m1_tick14", NA'(tick[1]), NA'(4'd14));
    write1(1, 3, 7);
    repeat (3) clear1(1);
    read1(1);
    chk("lit_m1_row1", spk[1], NA'(8'h80));
    write1(1, 0, 9);
    chk("lit_m1_err", NA'(err[1]), NA'(1'b1));
    chk("lit_m1_code", NA'(code[1]), NA'(2'b10));
    ack1(1, 1'b0);
    chk("lit_m1_ack_err", NA'(err[1]), NA'(1'b0));

    // Randomized traffic on both instances, with one reset in the middle
    for (int n = 0; n < 4000; n++) begin
      for (int d = 0; d < 2; d++) begin
        set_pkt(d, $urandom_range(0, NT - 1),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NA - 1));
        valid[d] = ($urandom_range(0, 1) == 1);
        rd[d]    = ($urandom_range(0, 2) == 0);
        clr[d]   = ($urandom_range(0, 4) == 0);
        ack[d]   = ($urandom_range(0, 3) == 0);
      end
      if (n == 2000) begin
        rst_n = 1'b0;
        model_reset();
      end
      if (n == 2003) rst_n = 1'b1;
      cyc();
    end
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axon_scheduler.md
Name: axon_scheduler

Overview:
- Parametrised successor to the core's fixed 16-tick × 256-axon spike scheduler.
- Buffers incoming router spikes in a circular array of NUM_TICKS rows × NUM_AXONS bits, and presents the current tick's row to the token controller.
- Adds configurable geometry, a relative-delay addressing mode, coded errors and registered read-out.
- Sits between the router and the token controller inside each neurosynaptic core.

Parameters:
- NUM_AXONS, 256, axons per row; power of 2, ≥ 4.
- NUM_TICKS, 16, delay slots; power of 2, ≥ 2.
- AXON_W, $clog2(NUM_AXONS), axon id width.
- TICK_W, $clog2(NUM_TICKS), tick field width.
- DELAY_MODE, 0, 0 = packet tick field is the absolute delivery tick; 1 = the field is a delay relative to current_tick.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- spike_packet  in  TICK_W+AXON_W+2  {tick_field, axon_id, debug[1:0]}; debug is ignored.
- spike_packet_valid  in  1  router offers a packet.
- spike_packet_ready  out  1  scheduler can accept a packet.
- read_request  in  1  latch the current row onto current_tick_spikes.
- current_tick_spikes  out  NUM_AXONS  registered copy of the current row.
- spikes_valid  out  1  one-cycle pulse when current_tick_spikes updates.
- clear_request  in  1  zero the current row and advance the tick.
- error  out  1  sticky error flag.
- error_code  out  2  01 = write to current tick, 10 = zero delay (mode 1 only), 11 = write while in error.
- error_ack  in  1  clears the error.
- current_tick  out  TICK_W  tick pointer.

Behaviour:
- Reset (async assert, sync release):
  - All rows 0, current_tick = 0, current_tick_spikes = 0.
  - spikes_valid = 0, error = 0, error_code = 00.
  - FSM in S_RUN; spike_packet_ready = 1 in S_RUN.
- FSM states: S_RUN, S_ERR.
  - spike_packet_ready = 1 in S_RUN, 0 in S_ERR.
  - read_request and clear_request are still serviced in S_ERR.
- Target tick:
  - DELAY_MODE 0: target = tick_field.
  - DELAY_MODE 1: target = (current_tick + tick_field) mod NUM_TICKS.
- Write accept (valid && ready, rising edge):
  - If target == current_tick (mode 0) or tick_field == 0 (mode 1): no write; go to S_ERR with error = 1 and code 01 or 10 on the same edge.
  - Otherwise set row[target][axon_id] = 1.
  - Duplicate writes are idempotent and raise no error.
- S_ERR:
  - error stays 1 until error_ack is sampled high, then S_RUN on the next edge.
  - A valid packet arriving in S_ERR is not accepted (ready = 0). If valid is high when error_ack is sampled, code updates to 11 but the flag still clears.
  - error_ack while in S_RUN is ignored.
- Read:
  - read_request sampled at edge N: current_tick_spikes = row[current_tick] and spikes_valid = 1 at N.
  - Data is visible in the cycle after N; spikes_valid drops at N+1 unless a read is repeated.
- Clear:
  - clear_request at edge N: row[current_tick] = 0, current_tick = (current_tick + 1) mod NUM_TICKS.
  - Wraps from NUM_TICKS−1 to 0.
- Simultaneous events on one edge:
  - read + clear: the read captures the pre-clear row.
  - write + clear: the write is checked against the pre-advance current_tick.
  - A write to current_tick+1 coincident with clear is legal and lands in the new current row.
- Reset mid-error or mid-write: everything returns to reset values; no partial writes.

Optional Feature:
- SCHED_STATS_EN defined:
  - Adds outputs stat_accepted[15:0], stat_dropped[15:0] and stat_dup[15:0].
  - stat_accepted counts accepted writes, stat_dropped counts error-causing packets, stat_dup counts writes to an already-set bit.
  - All saturate at 16'hFFFF and reset to 0.
- SCHED_STATS_EN undefined: no counters and no ports; behaviour otherwise identical.

Decomposition:
- Package sched_pkg holds:
  - error_code constants (ERR_NONE, ERR_CUR_TICK, ERR_ZERO_DELAY, ERR_WHILE_ERR);
  - the FSM state enum;
  - packet field offset functions of AXON_W/TICK_W.
- Sub-module sched_row_mem holds the NUM_TICKS × NUM_AXONS bit array with a set-bit port, a clear-row port and a row-read port.

Test Plan:
- Reset, write (t1,a5), (t1,a10), (t1,a20), (t2,a50), (t5,a200); read -> 0 spikes. Clear -> tick 1; read -> bits 5, 10, 20 only, spikes_valid pulses 1 cycle.
- At tick 6 write (t6,a80) -> error = 1, code 01, ready = 0 and bit 80 absent. Hold valid, assert error_ack -> error = 0 next edge, code 11, ready = 1.
- Same cycle: read + clear at tick 2 holding bits 50 and 100 -> output shows 50 and 100, current_tick = 3, row 2 zeroed.
- Clear through tick 15 -> current_tick = 0. Write (t0,a1) at tick 15 + clear in the same edge -> read shows bit 1 at tick 0.
- DELAY_MODE = 1, current_tick 14: write delay 3, axon 7 -> bit lands in row 1. Delay 0 -> error code 10.
- SCHED_STATS_EN: write axon 9 to tick 3 twice, plus one current-tick write -> accepted = 2, dup = 1, dropped = 1.
